// File: rtl/skew_feeder_pkg.sv
// Shared types and defaults for the systolic operand skew feeder.
package skew_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 8;

  // Step counter must hold 0 .. 3N-3 without wrapping.
  function automatic int step_cnt_w(input int n);
    return $clog2(3 * n - 1);
  endfunction

endpackage

// File: rtl/operand_bank.sv
// NxN operand storage with a single write port; contents exposed as one flat vector.
module operand_bank
  import skew_feeder_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_i,
  input  logic [$clog2(N)-1:0]    row_i,
  input  logic [$clog2(N)-1:0]    col_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic [N*N*DATA_W-1:0]   mem_o
);

  logic [N*N*DATA_W-1:0] mem_q;

  // Element (r,c) lives at slot r*N+c; out-of-range indices are silently dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= '0;
    end else if (we_i && (int'(row_i) < N) && (int'(col_i) < N)) begin
      mem_q[(int'(row_i) * N + int'(col_i)) * DATA_W +: DATA_W] <= data_i;
    end
  end

  assign mem_o = mem_q;

endmodule

// File: rtl/operand_skew_feeder.sv
// Streams stored A/B operands into an NxN systolic array with the diagonal
// skew the array expects: row i of A and column j of B are delayed by i / j steps.
module operand_skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic                   ld_mat,
  input  logic [$clog2(N)-1:0]   ld_row,
  input  logic [$clog2(N)-1:0]   ld_col,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [N*DATA_W-1:0]    a_out,
  output logic [N*DATA_W-1:0]    b_out,
  output logic                   pe_enable
);

  localparam int T_W    = step_cnt_w(N);
  localparam int LAST_T = 3 * N - 3;

  state_e              state_q, state_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [N*DATA_W-1:0] a_out_q, a_out_d;
  logic [N*DATA_W-1:0] b_out_q, b_out_d;
  logic                busy_q, done_q, ld_ready_q;

  logic [N*N*DATA_W-1:0] a_mem_s, b_mem_s;
  logic                  ld_acc_s, a_we_s, b_we_s, start_acc_s;

  assign ld_acc_s    = ld_valid & ld_ready_q;
  assign a_we_s      = ld_acc_s & ~ld_mat;
  assign b_we_s      = ld_acc_s & ld_mat;
  assign start_acc_s = start & ld_ready_q;

  operand_bank #(.N(N), .DATA_W(DATA_W)) u_bank_a (
    .clk(clk), .reset(reset), .we_i(a_we_s), .row_i(ld_row), .col_i(ld_col),
    .data_i(ld_data), .mem_o(a_mem_s)
  );

  operand_bank #(.N(N), .DATA_W(DATA_W)) u_bank_b (
    .clk(clk), .reset(reset), .we_i(b_we_s), .row_i(ld_row), .col_i(ld_col),
    .data_i(ld_data), .mem_o(b_mem_s)
  );

  // Next state and step counter.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc_s) begin
          state_d = ST_STREAM;
          t_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (t_q == T_W'(LAST_T)) begin
          state_d = ST_DONE;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Skewed lane selection for the upcoming step; a load landing on the start
  // edge is forwarded so the first step already sees the new value.
  always_comb begin
    a_out_d = '0;
    b_out_d = '0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(t_d) - i;
      if ((state_d == ST_STREAM) && (d >= 0) && (d < N)) begin
        if (a_we_s && (int'(ld_row) == i) && (int'(ld_col) == d)) begin
          a_out_d[i*DATA_W +: DATA_W] = ld_data;
        end else begin
          a_out_d[i*DATA_W +: DATA_W] = a_mem_s[(i*N + d)*DATA_W +: DATA_W];
        end
        if (b_we_s && (int'(ld_row) == d) && (int'(ld_col) == i)) begin
          b_out_d[i*DATA_W +: DATA_W] = ld_data;
        end else begin
          b_out_d[i*DATA_W +: DATA_W] = b_mem_s[(d*N + i)*DATA_W +: DATA_W];
        end
      end else begin
        a_out_d[i*DATA_W +: DATA_W] = '0;
        b_out_d[i*DATA_W +: DATA_W] = '0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      a_out_q    <= '0;
      b_out_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      a_out_q    <= a_out_d;
      b_out_q    <= b_out_d;
      busy_q     <= (state_d == ST_STREAM);
      done_q     <= (state_d == ST_DONE);
      ld_ready_q <= (state_d != ST_STREAM);
    end
  end

  assign a_out     = a_out_q;
  assign b_out     = b_out_q;
  assign busy      = busy_q;
  assign pe_enable = busy_q;
  assign done      = done_q;
  assign ld_ready  = ld_ready_q;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based model of the expected per-cycle outputs.
module tb_operand_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            reset;
  logic            ld_valid, ld_ready, ld_mat;
  logic [1:0]      ld_row, ld_col;
  logic [DW-1:0]   ld_data;
  logic            start, busy, done, pe_enable;
  logic [N*DW-1:0] a_out, b_out;

  operand_skew_feeder #(.N(N), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_mat(ld_mat), .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done), .a_out(a_out), .b_out(b_out),
    .pe_enable(pe_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
    logic            busy;
    logic            done;
    logic            ready;
  } exp_t;

  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  exp_t          cur_exp;
  exp_t          q [$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            chk_en = 1'b0;

  function automatic exp_t idle_rec();
    exp_t r;
    r = '0;
    r.ready = 1'b1;
    return r;
  endfunction

  function automatic exp_t done_rec();
    exp_t r;
    r = '0;
    r.done  = 1'b1;
    r.ready = 1'b1;
    return r;
  endfunction

  // Expected outputs at step t straight from the skew rule.
  function automatic exp_t stream_rec(input int t);
    exp_t r;
    r = '0;
    r.busy = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (t - i >= 0 && t - i < N) begin
        r.a[i*DW +: DW] = ma[i][t-i];
        r.b[i*DW +: DW] = mb[t-i][i];
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    cur_exp = idle_rec();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
  end

  // Reference model: advances on each rising edge from the sampled inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (reset !== 1'b1) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            ma[r][c] = '0;
            mb[r][c] = '0;
          end
        q.delete();
        cur_exp = idle_rec();
      end else begin
        bit rdy;
        rdy = cur_exp.ready;
        if (ld_valid && rdy && int'(ld_row) < N && int'(ld_col) < N) begin
          if (ld_mat) mb[ld_row][ld_col] = ld_data;
          else        ma[ld_row][ld_col] = ld_data;
        end
        if (start && rdy) begin
          q.delete();
          for (int t = 0; t <= 3*N-3; t++) q.push_back(stream_rec(t));
          q.push_back(done_rec());
        end
        if (q.size() > 0) cur_exp = q.pop_front();
        else              cur_exp = idle_rec();
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_out", a_out, cur_exp.a);
      chk("b_out", b_out, cur_exp.b);
      chk("busy", busy, cur_exp.busy);
      chk("pe_enable", pe_enable, cur_exp.busy);
      chk("done", done, cur_exp.done);
      chk("ld_ready", ld_ready, cur_exp.ready);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b0; ld_valid = 1'b0; ld_mat = 1'b0; ld_row = '0; ld_col = '0;
    ld_data = '0; start = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_a_out", a_out, 0);
    reset = 1'b1;

    // A[i][k] = 4i+k+1, B = identity.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ld_valid = 1'b1; ld_mat = 1'b0; ld_row = 2'(r); ld_col = 2'(c);
        ld_data = 8'(4*r + c + 1);
        tick();
        ld_mat = 1'b1; ld_data = (r == c) ? 8'd1 : 8'd0;
        tick();
      end
    ld_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      if (cnt == 0) chk("t0_b_lane0", b_out[7:0], 1);
      if (cnt == 2) chk("t2_b_lane2", b_out[23:16], 0);
      if (cnt == 3) begin
        chk("t3_a_out", a_out, 32'h0D0A0704);
        chk("t3_model_a", cur_exp.a, 32'h0D0A0704);
      end
      if (cnt == 5) begin
        start = 1'b1; ld_valid = 1'b1; ld_mat = 1'b0; ld_row = 2'd0; ld_col = 2'd0;
        ld_data = 8'hEE;
        chk("stream_ld_ready", ld_ready, 0);
      end else begin
        start = 1'b0; ld_valid = 1'b0;
      end
      cnt++;
      tick();
    end
    start = 1'b0; ld_valid = 1'b0;
    chk("busy_cycles", cnt, 10);
    chk("done_pulse", done, 1);
    tick();
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("after_a_out", a_out, 0);

    // Stored data persists; reset mid-stream aborts and clears storage.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("persist_a00", a_out[7:0], 1);
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_a_out", a_out, 0);
    chk("abort_ld_ready", ld_ready, 1);
    reset = 1'b1;
    tick();
    chk("abort_no_done", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      if (cnt == 3) chk("cleared_a_out", a_out, 0);
      cnt++;
      tick();
    end
    chk("rst_stream_len", cnt, 10);
    tick();

    // Load together with start, then back-to-back start in the DONE cycle.
    ld_valid = 1'b1; ld_mat = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 8'd9;
    start = 1'b1;
    tick();
    ld_valid = 1'b0; start = 1'b0;
    chk("fwd_a00", a_out[7:0], 9);
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("reach_done", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_a00", a_out[7:0], 9);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      reset    = ($urandom_range(0, 63) != 0);
      ld_valid = 1'($urandom_range(0, 1));
      ld_mat   = 1'($urandom_range(0, 1));
      ld_row   = 2'($urandom_range(0, 3));
      ld_col   = 2'($urandom_range(0, 3));
      ld_data  = 8'($urandom);
      start    = ($urandom_range(0, 11) == 0);
      tick();
    end
    reset = 1'b1; ld_valid = 1'b0; start = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
